gpr_dump: RTL and testbench

Debug reader for the general-purpose register file. On request, it halts the core through a halt handshake and walks the register file's read port from r0 to r(NUM_REGS-1). Each register value goes out as one beat on a valid/ready stream, followed by a 32-bit additive checksum beat. It sits beside the register file and borrows a read port while the core is halted, feeding a debug UART or trace buffer.

---
 rtl/gpr_dbg_pkg.sv | 18 +
 rtl/gpr_dump.sv | 153 +++++++++++++++
 tb/tb_gpr_dump.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_dbg_pkg.sv
// Shared definitions for the GPR debug dump path: FSM states and default widths.
package gpr_dbg_pkg;

    localparam int unsigned GPR_ADDR_W = 5;
    localparam int unsigned GPR_DATA_W = 32;
    // Checksum width, shared with the host-side checker.
    localparam int unsigned CSUM_W     = GPR_DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HALT = 3'd1,
        ST_READ = 3'd2,
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4,
        ST_FIN  = 3'd5
    } dump_state_e;

endpackage

// File: rtl/gpr_dump.sv
// Halts the core, walks the register file read port and streams every register
// followed by an additive checksum beat on a valid/ready interface.
module gpr_dump
    import gpr_dbg_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ADDR_W    = GPR_ADDR_W,
    parameter int unsigned DATA_W    = GPR_DATA_W,
    parameter bit          SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_idx,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_ZERO ? ADDR_W'(1) : ADDR_W'(0);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [ADDR_W-1:0] m_idx_q, m_idx_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic              halt_req_q, halt_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs_c;

    assign hs_c = m_valid_q && m_ready;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        rd_addr_d  = rd_addr_q;
        m_data_d   = m_data_q;
        m_idx_d    = m_idx_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        halt_req_d = halt_req_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HALT;
                    csum_d     = '0;
                    idx_d      = FIRST_IDX;
                    halt_req_d = 1'b1;
                end
            end
            ST_HALT: begin
                // rd_addr is registered, so it is loaded on the way into READ.
                if (halt_ack) begin
                    state_d   = ST_READ;
                    rd_addr_d = idx_q;
                end
            end
            ST_READ: begin
                m_data_d  = rd_data;
                m_idx_d   = idx_q;
                csum_d    = csum_q + rd_data;
                m_valid_d = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (hs_c) begin
                    if (idx_q == LAST_IDX) begin
                        state_d   = ST_CSUM;
                        m_data_d  = csum_q;
                        m_idx_d   = '0;
                        m_last_d  = 1'b1;
                    end else begin
                        state_d   = ST_READ;
                        m_valid_d = 1'b0;
                        idx_d     = idx_q + ADDR_W'(1);
                        rd_addr_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (hs_c) begin
                    state_d    = ST_FIN;
                    m_valid_d  = 1'b0;
                    m_last_d   = 1'b0;
                    halt_req_d = 1'b0;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            csum_q     <= '0;
            rd_addr_q  <= '0;
            m_data_q   <= '0;
            m_idx_q    <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            halt_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            rd_addr_q  <= rd_addr_d;
            m_data_q   <= m_data_d;
            m_idx_q    <= m_idx_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            halt_req_q <= halt_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign halt_req = halt_req_q;
    assign rd_addr  = rd_addr_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_idx    = m_idx_q;
    assign m_last   = m_last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_gpr_dump.sv
// Bench for gpr_dump: a model register file plus an expected-beat queue built
// from the register contents, checked against both a normal and a skip-r0 instance.
module tb_gpr_dump;

    localparam int unsigned N     = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int          BOUND = 2000;

    logic clk = 1'b0;
    logic rst;
    logic start0, start1, halt_ack, m_ready;

    logic          halt_req0, m_valid0, m_last0, busy0, done0;
    logic [AW-1:0] rd_addr0, m_idx0;
    logic [DW-1:0] rd_data0, m_data0;
    logic          halt_req1, m_valid1, m_last1, busy1, done1;
    logic [AW-1:0] rd_addr1, m_idx1;
    logic [DW-1:0] rd_data1, m_data1;

    logic [DW-1:0] gpr [N];
    assign rd_data0 = gpr[rd_addr0];
    assign rd_data1 = gpr[rd_addr1];

    // Observed signals of whichever instance the current dump targets.
    logic          sel;
    logic          o_halt_req, o_valid, o_last, o_busy, o_done;
    logic [AW-1:0] o_idx;
    logic [DW-1:0] o_data;
    assign o_halt_req = sel ? halt_req1 : halt_req0;
    assign o_valid    = sel ? m_valid1  : m_valid0;
    assign o_last     = sel ? m_last1   : m_last0;
    assign o_busy     = sel ? busy1     : busy0;
    assign o_done     = sel ? done1     : done0;
    assign o_idx      = sel ? m_idx1    : m_idx0;
    assign o_data     = sel ? m_data1   : m_data0;

    always #5 clk = ~clk;

    gpr_dump #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .halt_req(halt_req0), .halt_ack(halt_ack),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .m_valid(m_valid0), .m_ready(m_ready),
        .m_data(m_data0), .m_idx(m_idx0), .m_last(m_last0), .busy(busy0), .done(done0)
    );

    gpr_dump #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .halt_req(halt_req1), .halt_ack(halt_ack),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .m_valid(m_valid1), .m_ready(m_ready),
        .m_data(m_data1), .m_idx(m_idx1), .m_last(m_last1), .busy(busy1), .done(done1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [DW-1:0] exp_d [$];
    logic [AW-1:0] exp_i [$];
    logic          exp_l [$];

    // One dump: s selects the instance, hdelay delays halt_ack, rmode picks the
    // m_ready pattern (0 always, 1 one-in-three, 2 random), restart_n / abort_n
    // inject a stray start or an async reset at that cycle (-1 = none).
    task automatic run_dump(input bit s, input int hdelay, input int rmode,
                            input int restart_n, input int abort_n);
        int            n, first_n, nb, skip;
        bit            fin, held;
        logic [DW-1:0] sum, hd;
        logic [AW-1:0] hi;
        logic          hl;

        sel  = s;
        skip = s ? 1 : 0;
        nb   = int'(N) - skip;
        exp_d.delete(); exp_i.delete(); exp_l.delete();
        sum = '0;
        for (int i = skip; i < int'(N); i++) begin
            exp_d.push_back(gpr[i]);
            exp_i.push_back(AW'(i));
            exp_l.push_back(1'b0);
            sum = sum + gpr[i];
        end
        exp_d.push_back(sum);
        exp_i.push_back('0);
        exp_l.push_back(1'b1);

        @(negedge clk);
        start0   = !s;
        start1   = s;
        halt_ack = (hdelay == 0);
        m_ready  = 1'b1;
        @(posedge clk);

        n = 0; fin = 0; held = 0; first_n = -1;
        hd = '0; hi = '0; hl = 1'b0;
        while (!fin && n < BOUND) begin
            @(negedge clk);
            // Inputs for the next edge; outputs are registered so they are unaffected.
            start0 = 1'b0;
            start1 = 1'b0;
            if (n == restart_n) begin
                start0 = !s;
                start1 = s;
            end
            halt_ack = (n >= hdelay);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (n % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase

            if (n == 0) begin
                check_eq("busy_after_start", DW'(o_busy), DW'(1));
                check_eq("halt_req_after_start", DW'(o_halt_req), DW'(1));
            end
            if (held) begin
                check_eq("stall_valid", DW'(o_valid), DW'(1));
                check_eq("stall_data", o_data, hd);
                check_eq("stall_idx", DW'(o_idx), DW'(hi));
                check_eq("stall_last", DW'(o_last), DW'(hl));
            end
            held = 0;
            if (o_valid) begin
                if (first_n < 0) begin
                    first_n = n;
                    check_eq("first_valid_cycle", DW'(n), DW'(2 + hdelay));
                    check_eq("halt_req_in_walk", DW'(o_halt_req), DW'(1));
                end
                if (m_ready) begin
                    if (exp_d.size() == 0) begin
                        check_eq("extra_beat", DW'(1), DW'(0));
                    end else begin
                        check_eq("beat_data", o_data, exp_d.pop_front());
                        check_eq("beat_idx", DW'(o_idx), DW'(exp_i.pop_front()));
                        check_eq("beat_last", DW'(o_last), DW'(exp_l.pop_front()));
                    end
                end else begin
                    held = 1;
                    hd = o_data; hi = o_idx; hl = o_last;
                end
            end
            if (n == abort_n) begin
                rst = 1'b0;
                #1;
                check_eq("abort_valid", DW'(o_valid), DW'(0));
                check_eq("abort_halt_req", DW'(o_halt_req), DW'(0));
                check_eq("abort_busy", DW'(o_busy), DW'(0));
                start0 = 1'b0;
                start1 = 1'b0;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("abort_no_done", DW'(o_done), DW'(0));
                end
                return;
            end
            if (o_done) begin
                fin = 1;
                if (rmode == 0)
                    check_eq("done_cycle", DW'(n), DW'(2 * nb + 3 + hdelay));
                check_eq("beats_left", DW'(exp_d.size()), DW'(0));
                check_eq("done_halt_req", DW'(o_halt_req), DW'(0));
                check_eq("done_busy", DW'(o_busy), DW'(0));
                check_eq("done_valid", DW'(o_valid), DW'(0));
            end
            @(posedge clk);
            n++;
        end
        if (!fin) begin
            check_eq("timeout", DW'(0), DW'(1));
        end else begin
            start0 = 1'b0;
            start1 = 1'b0;
            @(negedge clk);
            check_eq("done_width", DW'(o_done), DW'(0));
            check_eq("idle_busy", DW'(o_busy), DW'(0));
        end
    endtask

    initial begin
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0; halt_ack = 1'b0; m_ready = 1'b0; sel = 1'b0;
        for (int i = 0; i < int'(N); i++) gpr[i] = DW'(i) * 32'h01010101;
        #1;
        check_eq("rst_halt_req", DW'(halt_req0), DW'(0));
        check_eq("rst_valid", DW'(m_valid0), DW'(0));
        check_eq("rst_busy", DW'(busy0), DW'(0));
        check_eq("rst_done", DW'(done0), DW'(0));
        check_eq("rst_data", m_data0, DW'(0));
        check_eq("rst_rd_addr", DW'(rd_addr0), DW'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Ramp preload: plain, delayed halt_ack, throttled ready.
        run_dump(1'b0, 0, 0, -1, -1);
        run_dump(1'b0, 10, 0, -1, -1);
        run_dump(1'b0, 0, 1, -1, -1);

        // All-ones with r0 skipped.
        for (int i = 0; i < int'(N); i++) gpr[i] = '1;
        run_dump(1'b1, 0, 0, -1, -1);

        // Stray start mid-walk and during FIN, then a second dump.
        for (int i = 0; i < int'(N); i++) gpr[i] = DW'(i) * 32'h01010101;
        run_dump(1'b0, 0, 0, 12, -1);
        run_dump(1'b0, 0, 0, 2 * int'(N) + 2, -1);
        run_dump(1'b0, 0, 0, -1, -1);

        // Reset at beat 12, then a fresh dump.
        run_dump(1'b0, 0, 0, -1, 26);
        run_dump(1'b0, 0, 0, -1, -1);

        // Random contents, instance, halt delay and backpressure.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < int'(N); i++) gpr[i] = $urandom;
            run_dump(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 2, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
